// File: rtl/ac_input_conditioner.sv
// ac_input_conditioner: sync/debounce of the inc/dec switches, tick generator,
// press latching with auto-repeat, and tick-aligned stable command outputs.
// Ports:
//   clk_2        system clock
//   reset        async active-low reset
//   swi_increase raw increase switch (async, bouncy)
//   swi_decrease raw decrease switch (async, bouncy)
//   tick         one-cycle pulse every TICK_DIV cycles
//   tick_led     toggles on every tick
//   cmd_increase increase command, held for one tick period
//   cmd_decrease decrease command, held for one tick period
//   pending      {dec_req, inc_req} request latches
`timescale 1ns/1ps
module ac_input_conditioner #(
  parameter int TICK_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_TICKS    = 4
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       swi_increase,
  input  logic       swi_decrease,
  output logic       tick,
  output logic       tick_led,
  output logic       cmd_increase,
  output logic       cmd_decrease,
  output logic [1:0] pending
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_TICKS - 1);

  // Channel index 0 = increase, 1 = decrease.
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  tick_q, tick_d;
  logic                  led_q, led_d;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            stable_q, stable_d;
  logic [1:0][DW-1:0]    dcnt_q, dcnt_d;
  logic [1:0][RW-1:0]    rcnt_q, rcnt_d;
  logic [1:0]            req_q, req_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [1:0]            flip, press, rpt;

  always_comb begin
    tick_d   = (tcnt_q == TLAST);
    tcnt_d   = tick_d ? '0 : tcnt_q + 1'b1;
    led_d    = led_q ^ tick_d;
    stable_d = stable_q;
    dcnt_d   = '0;
    rcnt_d   = '0;
    req_d    = req_q;
    flip     = '0;
    press    = '0;
    rpt      = '0;

    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != stable_q[k]) begin
        if (dcnt_q[k] == DLAST) begin
          flip[k]     = 1'b1;
          stable_d[k] = sync2_q[k];
        end else begin
          dcnt_d[k] = dcnt_q[k] + 1'b1;
        end
      end

      press[k] = flip[k] & sync2_q[k];

      // Repeat counts ticks of a held switch; a fresh press restarts it.
      if (press[k]) begin
        rcnt_d[k] = '0;
      end else if (stable_q[k]) begin
        rcnt_d[k] = rcnt_q[k];
        if (tick_q) begin
          if (rcnt_q[k] == RLAST) begin
            rpt[k]    = 1'b1;
            rcnt_d[k] = '0;
          end else begin
            rcnt_d[k] = rcnt_q[k] + 1'b1;
          end
        end
      end

      // A set landing on the consuming tick wins so the press is kept.
      if (press[k] | rpt[k]) begin
        req_d[k] = 1'b1;
      end else if (tick_q) begin
        req_d[k] = 1'b0;
      end
    end

    // Both pending at once cancel each other.
    cmd_d = cmd_q;
    if (tick_q) begin
      cmd_d[0] = req_q[0] & ~req_q[1];
      cmd_d[1] = req_q[1] & ~req_q[0];
    end
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      tcnt_q   <= '0;
      tick_q   <= 1'b0;
      led_q    <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      req_q    <= '0;
      cmd_q    <= '0;
    end else begin
      tcnt_q   <= tcnt_d;
      tick_q   <= tick_d;
      led_q    <= led_d;
      sync1_q  <= {swi_decrease, swi_increase};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      req_q    <= req_d;
      cmd_q    <= cmd_d;
    end
  end

  assign tick         = tick_q;
  assign tick_led     = led_q;
  assign cmd_increase = cmd_q[0];
  assign cmd_decrease = cmd_q[1];
  assign pending      = req_q;

endmodule
